instruction_fetch: RTL

//   Fetch stage of the 8-bit CPU, directly upstream of InstructionDecoder.
//   - Owns the program counter and issues req/ack reads to instruction memory.
//   - Latches each returned byte into the instruction register (instr).
//   - Presents instr with a valid/ready handshake; instr drives the decoder's 8-bit input directly.
//   - Redirects the PC on taken jumps (jump/jumpz/jumpnz/jumpc/jumpnc resolved downstream).

---
 rtl/instruction_fetch_pkg.sv | 16 +
 rtl/instruction_fetch_pc.sv | 27 ++
 rtl/instruction_fetch.sv | 109 ++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: widths, reset vector and state encoding.
package instruction_fetch_pkg;

  localparam int IF_ADDR_W = 8;
  localparam int IF_DATA_W = 8;
  localparam logic [IF_ADDR_W-1:0] IF_RESET_VECTOR = 8'h00;

  // Encodings are fixed so the decoder side and debug tools agree on them.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_pc.sv
// Program counter: async reset to the reset vector, branch load beats increment.
import instruction_fetch_pkg::*;

module program_counter #(
  parameter int                ADDR_W       = IF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = IF_RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // PC update; increment wraps modulo 2^ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_VECTOR;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues req/ack reads at the PC, latches the returned byte into the
// instruction register and hands it downstream with a valid/ready handshake.
// state | meaning
// IDLE  | not fetching (halted or just out of reset)
// FETCH | request outstanding at pc
// HOLD  | instr valid, waiting for the consumer
// FLUSH | branch arrived mid-request; finish the old read and drop its data
import instruction_fetch_pkg::*;

module instruction_fetch #(
  parameter int                ADDR_W       = IF_ADDR_W,
  parameter int                DATA_W       = IF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = IF_RESET_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc
);

  fetch_state_t      state, next_state;
  logic [ADDR_W-1:0] flush_addr;
  logic              fetch_done;

  // A fetch only completes when no branch overrides it in the same cycle.
  assign fetch_done = (state == S_FETCH) && mem_ack && !branch_taken;

  program_counter #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load   (branch_taken),
    .target (branch_target),
    .inc    (fetch_done),
    .pc     (pc)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; branch has priority over every other event.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (branch_taken || !halt) next_state = S_FETCH;
      end
      S_FETCH: begin
        if (branch_taken)  next_state = mem_ack ? S_FETCH : S_FLUSH;
        else if (mem_ack)  next_state = S_HOLD;
      end
      S_HOLD: begin
        if (branch_taken)     next_state = S_FETCH;
        else if (instr_ready) next_state = halt ? S_IDLE : S_FETCH;
      end
      S_FLUSH: begin
        if (branch_taken)  next_state = S_FLUSH;
        else if (mem_ack)  next_state = S_FETCH;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Instruction register, valid flag and the address frozen for a flushed read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      flush_addr  <= '0;
    end else begin
      if (branch_taken) begin
        instr_valid <= 1'b0;
      end else if (fetch_done) begin
        instr       <= mem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if ((state == S_HOLD) && instr_ready) begin
        instr_valid <= 1'b0;
      end
      // pc moves to the target immediately, so the outstanding address is kept here.
      if ((state == S_FETCH) && branch_taken && !mem_ack) begin
        flush_addr <= pc;
      end
    end
  end

  assign mem_req  = (state == S_FETCH) || (state == S_FLUSH);
  assign mem_addr = (state == S_FLUSH) ? flush_addr : pc;

endmodule
